// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-like decode/execute slice: opcode
// enumeration, instruction field positions, datapath widths and the
// immediate sign-extension helper.
// Optional feature macro: ALU_MUL_EN (opcode 13 becomes an unsigned multiply).
package mips_pkg;

    localparam int PC_W   = 6;
    localparam int DATA_W = 32;

    // Instruction field positions within the 32-bit word
    localparam int OP_HI    = 31;
    localparam int OP_LO    = 28;
    localparam int ISEL_BIT = 27;
    localparam int RD_HI    = 26;
    localparam int RD_LO    = 21;
    localparam int RS_HI    = 20;
    localparam int RS_LO    = 15;
    localparam int RT_HI    = 14;
    localparam int RT_LO    = 9;
    localparam int IMM_HI   = 14;
    localparam int IMM_LO   = 0;
    localparam int IMM_W    = IMM_HI - IMM_LO + 1;
    localparam int REG_W    = RD_HI - RD_LO + 1;

    // Opcode 13 is MUL only when ALU_MUL_EN is defined; otherwise it is a NOP.
    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOR   = 4'd5,
        OP_SLL   = 4'd6,
        OP_SRL   = 4'd7,
        OP_SRA   = 4'd8,
        OP_SLT   = 4'd9,
        OP_SLTU  = 4'd10,
        OP_PASSB = 4'd11,
        OP_CMP   = 4'd12,
        OP_MUL   = 4'd13,
        OP_NOP   = 4'd14,
        OP_NOP15 = 4'd15
    } op_t;

    // Replicate bit 14 of the immediate up to the datapath width
    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: opcode, operand A and operand B in, result and
// Overflow/Equal/Carry flags out. Unused opcodes drive zero.
// Optional feature macro: ALU_MUL_EN (opcode 13 = low half of unsigned A*B).
module alu_core #(
    parameter int DATA_W = mips_pkg::DATA_W
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              overflow,
    output logic              equal,
    output logic              carry
);
    import mips_pkg::*;

    localparam int SH_W = $clog2(DATA_W);
    localparam int MSB  = DATA_W - 1;

    op_t                      op_e;
    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic        [DATA_W:0]   sum;
    logic        [DATA_W:0]   diff;
    logic        [SH_W-1:0]   shamt;
    logic                     add_ovf;
    logic                     sub_ovf;

    assign op_e  = op_t'(op);
    assign a_s   = $signed(a);
    assign b_s   = $signed(b);
    assign shamt = b[SH_W-1:0];

    // One-bit-wider add/subtract so bit DATA_W carries the carry-out / borrow
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // Signed overflow: same-sign add changing sign, or opposite-sign
    // subtract whose result sign departs from A
    assign add_ovf = (a[MSB] == b[MSB]) && (sum[MSB]  != a[MSB]);
    assign sub_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);

    // Equality is reported for every opcode on the final operands
    assign equal = (a == b);

    // Result and arithmetic flags selected by opcode
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        carry    = 1'b0;
        case (op_e)
            OP_ADD: begin
                result   = sum[DATA_W-1:0];
                carry    = sum[DATA_W];
                overflow = add_ovf;
            end
            OP_SUB: begin
                result   = diff[DATA_W-1:0];
                carry    = ~diff[DATA_W];
                overflow = sub_ovf;
            end
            OP_CMP: begin
                // Flags only; the difference is discarded
                carry    = ~diff[DATA_W];
                overflow = sub_ovf;
            end
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_NOR:   result = ~(a | b);
            OP_SLL:   result = a << shamt;
            OP_SRL:   result = a >> shamt;
            OP_SRA:   result = $unsigned(a_s >>> shamt);
            OP_SLT:   result = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
            OP_SLTU:  result = {{(DATA_W-1){1'b0}}, (a < b)};
            OP_PASSB: result = b;
`ifdef ALU_MUL_EN
            OP_MUL:   result = a * b;
`endif
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/mips_decode_exec.sv
// Decode-and-execute slice of the single-cycle MIPS-like core. Holds the
// instruction counter, splits the instruction word into register addresses
// and ALU control, muxes the sign-extended immediate onto operand B and
// instantiates the ALU. Everything except pc is combinational.
// Optional feature macro: ALU_MUL_EN (opcode 13 = MUL with write-back).
module mips_decode_exec #(
    parameter int PC_W   = mips_pkg::PC_W,
    parameter int DATA_W = mips_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    output logic [PC_W-1:0]   pc,
    output logic [5:0]        rs,
    output logic [5:0]        rt,
    output logic [5:0]        rd,
    output logic              reg_we,
    output logic [DATA_W-1:0] alu_result,
    output logic              overflow,
    output logic              equal,
    output logic              carry
);
    import mips_pkg::*;

    op_t               op;
    logic              isel;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] opb;

    // Instruction counter: free-running, wraps modulo 2**PC_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else begin
            pc <= pc + PC_W'(1);
        end
    end

    assign op   = op_t'(instruction[OP_HI:OP_LO]);
    assign isel = instruction[ISEL_BIT];
    assign rd   = instruction[RD_HI:RD_LO];
    assign rs   = instruction[RS_HI:RS_LO];
    assign rt   = instruction[RT_HI:RT_LO];
    assign imm  = instruction[IMM_HI:IMM_LO];

    // rt is always decoded; isel only decides whether rd2 or the immediate feeds B
    assign opb = isel ? DATA_W'(sext_imm(imm)) : rd2;

    // Write enable for every opcode that produces a write-back value;
    // r0 handling is left to the register file
    always_comb begin
        reg_we = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR,
            OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_PASSB: reg_we = 1'b1;
`ifdef ALU_MUL_EN
            OP_MUL: reg_we = 1'b1;
`endif
            default: reg_we = 1'b0;
        endcase
    end

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op       (instruction[OP_HI:OP_LO]),
        .a        (rd1),
        .b        (opb),
        .result   (alu_result),
        .overflow (overflow),
        .equal    (equal),
        .carry    (carry)
    );

endmodule

// File: tb/tb_mips_decode_exec.sv
// Self-checking bench for mips_decode_exec: directed literal cases plus
// randomized instructions checked every cycle against a behavioural model.
module tb_mips_decode_exec;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [5:0]  pc;
    logic [5:0]  rs;
    logic [5:0]  rt;
    logic [5:0]  rd;
    logic        reg_we;
    logic [31:0] alu_result;
    logic        overflow;
    logic        equal;
    logic        carry;

    int passed = 0;
    int total  = 0;
    bit chk_en = 0;
    int mpc    = 0;

    typedef struct {
        logic [31:0] res;
        logic        ov;
        logic        eq;
        logic        c;
        logic        we;
    } exp_t;

    mips_decode_exec dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .rd1         (rd1),
        .rd2         (rd2),
        .pc          (pc),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .reg_we      (reg_we),
        .alu_result  (alu_result),
        .overflow    (overflow),
        .equal       (equal),
        .carry       (carry)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, got, exp, $time);
        else
            passed++;
    endtask

    function automatic logic [31:0] mk(input int op, input int isel, input int rdv,
                                       input int rsv, input int imm15);
        logic [31:0] w;
        w = {op[3:0], isel[0], rdv[5:0], rsv[5:0], imm15[14:0]};
        return w;
    endfunction

    // Behavioural reference computed with wide integer arithmetic
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a,
                                   input logic [31:0] b2);
        exp_t e;
        int unsigned     op;
        logic [31:0]     b;
        int signed       ia, ib;
        longint signed   s;
        longint unsigned ua, ub, us;
        int unsigned     sh;
        op = int'(ins[31:28]);
        b  = ins[27] ? {{17{ins[14]}}, ins[14:0]} : b2;
        ia = a; ib = b;
        ua = {32'd0, a}; ub = {32'd0, b};
        sh = int'(b[4:0]);
        e.res = 0; e.ov = 0; e.c = 0;
        e.eq  = (a == b);
        e.we  = (op <= 11);
        case (op)
            0: begin
                us = ua + ub; e.res = us[31:0]; e.c = us[32];
                s = longint'(ia) + longint'(ib);
                e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            1, 12: begin
                us = ua - ub;
                if (op == 1) e.res = us[31:0];
                e.c = (a >= b);
                s = longint'(ia) - longint'(ib);
                e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2:  e.res = a & b;
            3:  e.res = a | b;
            4:  e.res = a ^ b;
            5:  e.res = ~(a | b);
            6:  e.res = a << sh;
            7:  e.res = a >> sh;
            8:  e.res = ia >>> sh;
            9:  e.res = (ia < ib) ? 1 : 0;
            10: e.res = (a < b) ? 1 : 0;
            11: e.res = b;
`ifdef ALU_MUL_EN
            13: begin
                us = ua * ub; e.res = us[31:0]; e.we = 1;
            end
`endif
            default: e.res = 0;
        endcase
        return e;
    endfunction

    // Reference instruction counter: cycles since reset, modulo 64
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mpc <= 0;
        else        mpc <= (mpc + 1) % 64;
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            exp_t e;
            e = model(instruction, rd1, rd2);
            check("cyc_pc",       {26'd0, pc}, mpc);
            check("cyc_result",   alu_result, e.res);
            check("cyc_overflow", {31'd0, overflow}, {31'd0, e.ov});
            check("cyc_equal",    {31'd0, equal},    {31'd0, e.eq});
            check("cyc_carry",    {31'd0, carry},    {31'd0, e.c});
            check("cyc_reg_we",   {31'd0, reg_we},   {31'd0, e.we});
            check("cyc_rd", {26'd0, rd}, {26'd0, instruction[26:21]});
            check("cyc_rs", {26'd0, rs}, {26'd0, instruction[20:15]});
            check("cyc_rt", {26'd0, rt}, {26'd0, instruction[14:9]});
        end
    end

    task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #2;
        instruction = ins;
        rd1 = a;
        rd2 = b;
        #1;
    endtask

    initial begin
        logic [31:0] edge_vals [5];
        edge_vals[0] = 32'h0000_0000; edge_vals[1] = 32'h0000_0001;
        edge_vals[2] = 32'h7FFF_FFFF; edge_vals[3] = 32'h8000_0000;
        edge_vals[4] = 32'hFFFF_FFFF;

        rst_n = 0;
        instruction = 0; rd1 = 0; rd2 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pc", {26'd0, pc}, 32'd0);
        chk_en = 1;
        @(negedge clk);
        #1 rst_n = 1;

        // Count through a full wrap
        for (int i = 1; i <= 65; i++) begin
            @(posedge clk);
            #1;
            check("count_pc", {26'd0, pc}, i % 64);
        end

        // Asynchronous reset between edges
        @(posedge clk);
        #2 rst_n = 0;
        #1 check("async_reset_pc", {26'd0, pc}, 32'd0);
        rst_n = 1;

        // ADD overflow and carry
        drive(mk(0, 0, 1, 2, 0), 32'h7FFF_FFFF, 32'd1);
        check("add_ovf_res", alu_result, 32'h8000_0000);
        check("add_ovf_ov", {31'd0, overflow}, 32'd1);
        check("add_ovf_c", {31'd0, carry}, 32'd0);
        check("add_ovf_we", {31'd0, reg_we}, 32'd1);
        drive(mk(0, 0, 1, 2, 0), 32'hFFFF_FFFF, 32'd1);
        check("add_c_res", alu_result, 32'd0);
        check("add_c_c", {31'd0, carry}, 32'd1);
        check("add_c_ov", {31'd0, overflow}, 32'd0);

        // Immediate path
        drive(mk(0, 1, 3, 4, 15'h7FFF), 32'd5, 32'h1234_5678);
        check("imm_neg_res", alu_result, 32'd4);
        check("imm_neg_c", {31'd0, carry}, 32'd1);
        drive(mk(11, 1, 3, 4, 15'h3FFF), 32'd0, 32'hDEAD_BEEF);
        check("imm_pos_b", alu_result, 32'h0000_3FFF);

        // SUB / CMP
        drive(mk(1, 0, 5, 6, 0), 32'd10, 32'd10);
        check("sub_eq_res", alu_result, 32'd0);
        check("sub_eq_eq", {31'd0, equal}, 32'd1);
        check("sub_eq_c", {31'd0, carry}, 32'd1);
        check("sub_eq_ov", {31'd0, overflow}, 32'd0);
        drive(mk(12, 0, 5, 6, 0), 32'd3, 32'd7);
        check("cmp_res", alu_result, 32'd0);
        check("cmp_c", {31'd0, carry}, 32'd0);
        check("cmp_eq", {31'd0, equal}, 32'd0);
        check("cmp_we", {31'd0, reg_we}, 32'd0);

        // Shifts, compares, logic
        drive(mk(8, 0, 1, 1, 0), 32'h8000_0000, 32'd4);
        check("sra", alu_result, 32'hF800_0000);
        drive(mk(7, 0, 1, 1, 0), 32'h8000_0000, 32'd4);
        check("srl", alu_result, 32'h0800_0000);
        drive(mk(9, 0, 1, 1, 0), 32'hFFFF_FFFF, 32'd1);
        check("slt", alu_result, 32'd1);
        drive(mk(10, 0, 1, 1, 0), 32'hFFFF_FFFF, 32'd1);
        check("sltu", alu_result, 32'd0);
        drive(mk(5, 0, 1, 1, 0), 32'd0, 32'd0);
        check("nor", alu_result, 32'hFFFF_FFFF);

        // Field decode on a fixed word (SUB with immediate 0xFFFFEE00)
        drive(32'h1A2A_6E00, 32'd0, 32'd0);
        check("dec_rd", {26'd0, rd}, 32'h11);
        check("dec_rs", {26'd0, rs}, 32'h14);
        check("dec_rt", {26'd0, rt}, 32'h37);
        check("dec_res", alu_result, 32'h0000_1200);

        // Opcode 13
        drive(mk(13, 0, 1, 2, 0), 32'd6, 32'd7);
`ifdef ALU_MUL_EN
        check("op13_res", alu_result, 32'd42);
        check("op13_we", {31'd0, reg_we}, 32'd1);
`else
        check("op13_res", alu_result, 32'd0);
        check("op13_we", {31'd0, reg_we}, 32'd0);
`endif

        // Randomized traffic checked by the per-cycle model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins, a, b;
            ins = $urandom;
            a   = $urandom;
            b   = $urandom;
            case ($urandom_range(0, 3))
                0: ;
                1: b = a;
                2: begin
                    a = edge_vals[$urandom_range(0, 4)];
                    b = edge_vals[$urandom_range(0, 4)];
                end
                default: ins[27] = 1'b0;
            endcase
            drive(ins, a, b);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
